// File: rtl/fpu_pkg.sv
// Shared FPU definitions: encoder-arbiter state encoding, requester indices
// and encoder flag bit positions.
package fpu_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ENC,
        ARB_DONE,
        ARB_DRAIN
    } fpu_arb_state_e;

    localparam int REQ_ROUND  = 0;
    localparam int REQ_CAST   = 1;
    localparam int REQ_ADDSUB = 2;
    localparam int REQ_MULDIV = 3;

    localparam int FLG_ZF   = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UF   = 2;
    localparam int FLG_INF  = 3;
    localparam int FLG_NANF = 4;

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: one-hot winner of the first set request
// bit found searching upward from ptr, wrapping around.
module fpu_rr_picker
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic found;
    int   idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_enc_arb.sv
// Round-robin arbiter sharing the fpu_enc result encoder among the FPU units.
// Optional encoder watchdog enabled by defining FPU_ENC_ARB_TIMEOUT_EN.
module fpu_enc_arb
    import fpu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int OPERAND_WIDTH  = 32,
    parameter int FLAG_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     fpu_clk,
    input  logic                     fpu_rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     busy_o,
    output logic                     fpu_enc_en_o,
    input  logic                     fpu_enc_ready_i,
    input  logic [OPERAND_WIDTH-1:0] fpu_result_i,
    input  logic [FLAG_WIDTH-1:0]    fpu_flags_i,
    output logic [NUM_REQ-1:0]       done_o,
    output logic [OPERAND_WIDTH-1:0] result_o,
    output logic [FLAG_WIDTH-1:0]    flags_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    fpu_arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       win_q, win_d;
    logic [NUM_REQ-1:0]       mask_q;
    logic [NUM_REQ-1:0]       pick;
    logic [PTR_W-1:0]         win_idx;
    logic [OPERAND_WIDTH-1:0] result_q;
    logic [FLAG_WIDTH-1:0]    flags_q;
    logic                     capture;
    logic                     tmo_hit;
    logic                     tmo_fire;

    // The unit that just finished may deassert late, so it is hidden for the
    // single IDLE cycle that follows its done pulse.
    fpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req_i & ~mask_q),
        .ptr    (ptr_q),
        .winner (pick)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_q[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        win_d    = win_q;
        capture  = 1'b0;
        tmo_fire = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|pick) begin
                    win_d   = pick;
                    gnt_d   = pick;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (|(req_i & win_q)) begin
                    state_d = ARB_ENC;
                end else begin
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                end
            end
            ARB_ENC: begin
                if (fpu_enc_ready_i) begin
                    capture = 1'b1;
                    gnt_d   = '0;
                    state_d = ARB_DONE;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    gnt_d    = '0;
                    state_d  = ARB_DONE;
                end
            end
            ARB_DONE: begin
                ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                state_d = fpu_enc_ready_i ? ARB_DRAIN : ARB_IDLE;
            end
            ARB_DRAIN: begin
                if (!fpu_enc_ready_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            win_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            mask_q  <= (state_q == ARB_DONE) ? win_q : '0;
            if (capture) begin
                result_q <= fpu_result_i;
                flags_q  <= fpu_flags_i;
            end else if (tmo_fire) begin
                result_q <= '0;
                flags_q  <= '0;
            end
        end
    end

`ifdef FPU_ENC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;

    // Counter restarts in GRANT so every ENC visit gets the full budget.
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == ARB_GRANT) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ARB_ENC) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            err_q <= tmo_fire;
        end
    end

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign gnt_o        = gnt_q;
    assign busy_o       = (state_q != ARB_IDLE);
    assign fpu_enc_en_o = (state_q == ARB_ENC);
    assign done_o       = (state_q == ARB_DONE) ? win_q : '0;
    assign result_o     = result_q;
    assign flags_o      = flags_q;

endmodule

// File: tb/tb_fpu_enc_arb.sv
// Scoreboard bench for fpu_enc_arb: directed transactions push expected
// completions; a negedge monitor pops and compares on every done pulse.
module tb_fpu_enc_arb;

`ifdef FPU_ENC_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic        fpu_clk;
    logic        fpu_rst_n;
    logic [3:0]  req_i;
    logic [3:0]  gnt_o;
    logic        busy_o;
    logic        fpu_enc_en_o;
    logic        fpu_enc_ready_i;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_flags_i;
    logic [3:0]  done_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        err_o;

    typedef struct packed {
        logic [3:0]  done;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   running  = 0;

    fpu_enc_arb #(
        .NUM_REQ        (4),
        .OPERAND_WIDTH  (32),
        .FLAG_WIDTH     (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .fpu_clk         (fpu_clk),
        .fpu_rst_n       (fpu_rst_n),
        .req_i           (req_i),
        .gnt_o           (gnt_o),
        .busy_o          (busy_o),
        .fpu_enc_en_o    (fpu_enc_en_o),
        .fpu_enc_ready_i (fpu_enc_ready_i),
        .fpu_result_i    (fpu_result_i),
        .fpu_flags_i     (fpu_flags_i),
        .done_o          (done_o),
        .result_o        (result_o),
        .flags_o         (flags_o),
        .err_o           (err_o)
    );

    initial fpu_clk = 1'b0;
    always #5 fpu_clk = ~fpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpu_clk);
        #1;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!fpu_enc_en_o && n < 40) begin
            tick();
            n++;
        end
        check("enc_en_wait", 32'(fpu_enc_en_o), 32'd1);
    endtask

    // Acts as the encoder: waits for enable, answers after 'delay' cycles.
    // With hold set, ready stays high (stale) and the caller releases it.
    task automatic applyStimulus(input logic [3:0] exp_gnt, input int delay,
                                 input logic [31:0] res, input logic [4:0] flg,
                                 input bit hold);
        wait_en();
        check("gnt_in_enc", 32'(gnt_o), 32'(exp_gnt));
        repeat (delay) tick();
        fpu_result_i    = res;
        fpu_flags_i     = flg;
        fpu_enc_ready_i = 1'b1;
        tick();
        check("en_drop", 32'(fpu_enc_en_o), 32'd0);
        check("gnt_clear_done", 32'(gnt_o), 32'd0);
        if (hold) fpu_result_i = 32'hDEAD_BEEF;
        else      fpu_enc_ready_i = 1'b0;
    endtask

    task automatic push(input logic [3:0] d, input logic [31:0] r,
                        input logic [4:0] f, input logic e);
        exp_t x;
        x.done = d;
        x.res  = r;
        x.flg  = f;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_gnt"},    32'(gnt_o),        32'd0);
        check({tag, "_busy"},   32'(busy_o),       32'd0);
        check({tag, "_en"},     32'(fpu_enc_en_o), 32'd0);
        check({tag, "_done"},   32'(done_o),       32'd0);
        check({tag, "_result"}, result_o,          32'd0);
        check({tag, "_flags"},  32'(flags_o),      32'd0);
        check({tag, "_err"},    32'(err_o),        32'd0);
    endtask

    always @(negedge fpu_clk) begin
        exp_t e;
        if (fpu_rst_n && running) begin
            check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
            check("done_onehot0", 32'($onehot0(done_o)), 32'd1);
            if (fpu_enc_en_o) check("en_with_gnt", 32'(|gnt_o), 32'd1);
            if (done_o != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_done",   32'(done_o),  32'(e.done));
                    check("sb_result", result_o,     e.res);
                    check("sb_flags",  32'(flags_o), 32'(e.flg));
                    check("sb_err",    32'(err_o),   32'(e.err));
                end
            end
        end
    end

    initial begin
        logic [3:0] g;
        fpu_rst_n       = 1'b0;
        req_i           = 4'b0000;
        fpu_enc_ready_i = 1'b0;
        fpu_result_i    = 32'd0;
        fpu_flags_i     = 5'd0;
        repeat (2) @(posedge fpu_clk);
        #1;
        checkOutput("reset");
        fpu_rst_n = 1'b1;
        running   = 1'b1;
        tick();

        // Contention from ptr=0: grants walk 0,1,2,3,0
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            push(g, 32'h1000_0000 + 32'(k), 5'(k + 1), 1'b0);
            applyStimulus(g, 1, 32'h1000_0000 + 32'(k), 5'(k + 1), 1'b0);
        end
        req_i = 4'b0000;
        repeat (2) tick();

        // Single request with latency checks (ptr=1 -> grant 2)
        req_i = 4'b0100;
        push(4'b0100, 32'h4F0A_5C3F, 5'b00000, 1'b0);
        tick();
        check("lat_gnt", 32'(gnt_o), 32'h4);
        check("lat_en_low", 32'(fpu_enc_en_o), 32'd0);
        tick();
        check("lat_en_high", 32'(fpu_enc_en_o), 32'd1);
        applyStimulus(4'b0100, 2, 32'h4F0A_5C3F, 5'b00000, 1'b0);
        req_i = 4'b0000;
        tick();

        // ptr is now 3: unit 3 beats unit 0, then unit 0 follows
        req_i = 4'b1001;
        push(4'b1000, 32'h8000_0001, 5'b10000, 1'b0);
        applyStimulus(4'b1000, 0, 32'h8000_0001, 5'b10000, 1'b0);
        req_i = 4'b0001;
        push(4'b0001, 32'h0000_0000, 5'b00001, 1'b0);
        applyStimulus(4'b0001, 1, 32'h0000_0000, 5'b00001, 1'b0);
        req_i = 4'b0000;
        tick();

        // Slow deassert: request still high in the IDLE cycle after done
        req_i = 4'b0001;
        push(4'b0001, 32'h7F80_0000, 5'b01000, 1'b0);
        applyStimulus(4'b0001, 0, 32'h7F80_0000, 5'b01000, 1'b0);
        tick();
        tick();
        req_i = 4'b0000;
        check("mask_no_regrant", 32'(gnt_o), 32'd0);
        check("mask_idle", 32'(busy_o), 32'd0);
        tick();

        // Abort in GRANT (ptr=1)
        req_i = 4'b0010;
        tick();
        check("abort_gnt", 32'(gnt_o), 32'h2);
        req_i = 4'b0000;
        tick();
        check("abort_gnt_clr", 32'(gnt_o), 32'd0);
        check("abort_en", 32'(fpu_enc_en_o), 32'd0);
        check("abort_idle", 32'(busy_o), 32'd0);
        tick();

        // ptr must still be 1 after the abort
        req_i = 4'b0011;
        push(4'b0010, 32'h3F80_0000, 5'b00100, 1'b0);
        applyStimulus(4'b0010, 1, 32'h3F80_0000, 5'b00100, 1'b0);

        // Stale ready while unit 3 is pending
        req_i = 4'b0001;
        push(4'b0001, 32'h1234_5678, 5'b00010, 1'b0);
        applyStimulus(4'b0001, 0, 32'h1234_5678, 5'b00010, 1'b1);
        req_i = 4'b1000;
        tick();
        check("drain_busy", 32'(busy_o), 32'd1);
        check("drain_en", 32'(fpu_enc_en_o), 32'd0);
        check("drain_gnt", 32'(gnt_o), 32'd0);
        tick();
        check("drain_en2", 32'(fpu_enc_en_o), 32'd0);
        check("drain_no_recapture", result_o, 32'h1234_5678);
        fpu_enc_ready_i = 1'b0;
        push(4'b1000, 32'hC000_0000, 5'b00000, 1'b0);
        applyStimulus(4'b1000, 1, 32'hC000_0000, 5'b00000, 1'b0);
        req_i = 4'b0000;
        tick();

        // Reset while in ENC, then a normal grant from ptr=0
        req_i = 4'b0100;
        wait_en();
        running   = 1'b0;
        fpu_rst_n = 1'b0;
        #1;
        checkOutput("async_rst");
        tick();
        req_i     = 4'b0000;
        fpu_rst_n = 1'b1;
        running   = 1'b1;
        tick();
        req_i = 4'b0001;
        push(4'b0001, 32'h0BAD_F00D, 5'b00011, 1'b0);
        applyStimulus(4'b0001, 1, 32'h0BAD_F00D, 5'b00011, 1'b0);
        req_i = 4'b0000;
        repeat (2) tick();

`ifdef FPU_ENC_ARB_TIMEOUT_EN
        // Encoder never answers: watchdog completes after 8 ENC cycles
        fpu_result_i = 32'hCAFE_F00D;
        fpu_flags_i  = 5'b11111;
        req_i = 4'b0010;
        push(4'b0010, 32'h0, 5'b00000, 1'b1);
        wait_en();
        repeat (7) tick();
        check("tmo_en_still", 32'(fpu_enc_en_o), 32'd1);
        check("tmo_no_done_yet", 32'(done_o), 32'd0);
        tick();
        check("tmo_en_low", 32'(fpu_enc_en_o), 32'd0);
        check("tmo_done", 32'(done_o), 32'h2);
        req_i = 4'b0000;
        repeat (2) tick();
`endif

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_enc_arb.md
Name: fpu_enc_arb

Overview:
- Round-robin arbiter and sequencer that shares the single fpu_enc result encoder among the FPU functional units: fround, fcast, faddsub and fmuldiv.
- Grants one requester at a time and drives the grant that steers the encoder operand mux.
- Runs the fpu_enc_en / fpu_enc_ready handshake, captures the encoded result and flags, and returns them to the granted unit with a one-cycle done pulse.
- Sits between the functional units and fpu_enc inside the FPU top.

Parameters:
- NUM_REQ, 4, number of requesters; index 0=fround, 1=fcast, 2=faddsub, 3=fmuldiv.
- OPERAND_WIDTH, 32, width of the encoded result.
- FLAG_WIDTH, 5, encoder flag vector {nanf, inf, uf, ovf, zf}; bit 0 = zf.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- fpu_clk  in  1  clock.
- fpu_rst_n  in  1  asynchronous reset, active-low.
- req_i  in  NUM_REQ  per-unit request; level; held until that unit's done.
- gnt_o  out  NUM_REQ  one-hot grant; drives the encoder operand mux select.
- busy_o  out  1  high in any state other than IDLE.
- fpu_enc_en_o  out  1  encoder enable.
- fpu_enc_ready_i  in  1  encoder ready.
- fpu_result_i  in  OPERAND_WIDTH  encoder result.
- fpu_flags_i  in  FLAG_WIDTH  encoder flags.
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted unit.
- result_o  out  OPERAND_WIDTH  captured result; held until the next capture.
- flags_o  out  FLAG_WIDTH  captured flags; held until the next capture.
- err_o  out  1  timeout error; pulses with done_o. Tied 0 without the optional feature.

Behaviour:
- Reset values: all outputs 0; state = IDLE; round-robin pointer ptr = 0.
- FSM states: IDLE, GRANT, ENC, DONE, DRAIN.
- IDLE:
  - If |req_i, pick the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - Register the winner in gnt_o and go to GRANT.
- GRANT: one cycle for operand-mux settling.
  - If req_i[winner] is still high, go to ENC.
  - Otherwise abort: clear gnt_o, return to IDLE, ptr unchanged, no done pulse.
- ENC:
  - fpu_enc_en_o = 1 and gnt_o held.
  - req_i is ignored here; the transaction completes even if the request drops.
  - When fpu_enc_ready_i is sampled high: load result_o/flags_o, clear fpu_enc_en_o, go to DONE.
- DONE: exactly one cycle.
  - done_o[winner] = 1; ptr = winner+1 modulo NUM_REQ; gnt_o cleared.
  - Next state is DRAIN if fpu_enc_ready_i is still high, else IDLE.
- DRAIN: wait for fpu_enc_ready_i low, then go to IDLE. This keeps a stale ready from completing the next transaction.
- Latency:
  - req at edge t gives gnt_o at t+1 and fpu_enc_en_o at t+2.
  - done_o follows the ready sample by 1 cycle.
  - Minimum back-to-back spacing is 4 cycles.
- Requester rule: a unit drops req_i in the cycle after its done_o. In that cycle (state IDLE) the arbiter masks req_i[prev winner] so a slow deassert is not re-granted.
- Simultaneous requests: the unit at index ptr has top priority, so no requester starves. Example: ptr=2, req=4'b1011 → grant index 3.
- Reset mid-transaction: everything returns to reset values immediately; fpu_enc_en_o drops asynchronously; no done is issued.
- gnt_o is never multi-hot. done_o is never multi-hot. fpu_enc_en_o is high only in ENC.

Optional Feature:
- Macro: FPU_ENC_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ENC and increments each ENC cycle.
  - On reaching TIMEOUT_CYCLES without ready: go to DONE, result_o = 0, flags_o = 0, err_o = 1 with the done pulse, fpu_enc_en_o dropped.
- Undefined: no counter; ENC waits indefinitely; err_o is constant 0.

Decomposition:
- Package fpu_pkg holds:
  - the state enum fpu_arb_state_e;
  - requester index constants REQ_ROUND, REQ_CAST, REQ_ADDSUB, REQ_MULDIV;
  - flag bit indices FLG_ZF, FLG_OVF, FLG_UF, FLG_INF, FLG_NANF.
- Sub-module fpu_rr_picker: purely combinational, inputs (req, ptr), output one-hot winner. Reusable elsewhere in the FPU.

Test Plan:
- Single request: req_i=4'b0100, encoder ready after 3 cycles with result 32'h4F0A5C3F and flags 5'b00000.
  - Response: gnt_o=4'b0100 at t+1, fpu_enc_en_o at t+2, done_o=4'b0100 once, result_o=32'h4F0A5C3F, ptr=3.
- Contention: req_i=4'b1111 held throughout.
  - Response: grants 0,1,2,3,0 in order; each done single-cycle; never two grants active.
- Abort: req_i[1] rises, then drops during GRANT.
  - Response: no fpu_enc_en_o, no done_o; back to IDLE; ptr unchanged.
- Stale ready: encoder holds ready for 2 cycles after en drops, while req_i[3] is pending.
  - Response: DRAIN observed; the next fpu_enc_en_o rises only after ready has been low; result not re-captured.
- Reset: fpu_rst_n pulsed low in ENC.
  - Response: all outputs 0 asynchronously; after release, req_i=4'b0001 is granted normally.
- With FPU_ENC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserts.
  - Response: done_o and err_o pulse in the cycle after the 8th ENC cycle; result_o=0; fpu_enc_en_o low.
